// File: rtl/rs232_rx_sipo.sv
// rs232_rx_sipo: RS232 receive stage, 8N1 (8E1 with RX_PARITY_EN), LSB first, mid-bit sampling.
// Latency: 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles from rxd fall to data_valid (+/-1 sync phase).
// Backpressure: none; data_valid/frame_err/parity_err are single-cycle strobes the consumer must take.
// Optional feature: define RX_PARITY_EN for 8E1 framing with even-parity checking.
module rs232_rx_sipo #(
   parameter int CLKS_PER_BIT = 434,
   parameter int DATA_BITS    = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rxd,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 data_valid,
   output logic                 frame_err,
   output logic                 parity_err,
   output logic                 busy
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int IW = $clog2(DATA_BITS);
   localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4,
      S_WAIT   = 3'd5
   } state_t;

   state_t                 state_q, state_d;
   logic                   sync1_q, rxs_q;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [IW-1:0]          bit_idx_q, bit_idx_d;
   logic [DATA_BITS-1:0]   shift_q, shift_d;
   logic [DATA_BITS-1:0]   data_q, data_d;
   logic                   dv_q, dv_d;
   logic                   fe_q, fe_d;
   logic [1:0]             settle_q, settle_d;
   logic                   armed_q, armed_d;
   logic                   settled;
   logic                   at_half, at_end;

   // per-state action strobes from the output process
   logic                   clr_idx;
   logic                   sample_bit;
   logic                   stop_good;
   logic                   stop_bad;
`ifdef RX_PARITY_EN
   logic                   sample_par;
   logic                   par_bad_q, par_bad_d;
   logic                   pe_q, pe_d;
`endif

   assign at_half = (cnt_q == HALF_CNT);
   assign at_end  = (cnt_q == LAST_CNT);
   // rxs only reflects the real line once both synchronizer stages have been reloaded after reset
   assign settled = (settle_q == 2'd2);

   // two-flop synchronizer; resets to the idle-high line level
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_q <= 1'b1;
         rxs_q   <= 1'b1;
      end else begin
         sync1_q <= rxd;
         rxs_q   <= sync1_q;
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= S_IDLE;
      else      state_q <= state_d;
   end

   // FSM next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            // a line found low right after reset must be seen high before any frame starts
            if (armed_q && !rxs_q)                 state_d = S_START;
            else if (!armed_q && settled && !rxs_q) state_d = S_WAIT;
         end
         S_START: begin
            if (at_half) state_d = rxs_q ? S_IDLE : S_DATA;
         end
         S_DATA: begin
            if (at_end && (bit_idx_q == LAST_BIT)) begin
`ifdef RX_PARITY_EN
               state_d = S_PARITY;
`else
               state_d = S_STOP;
`endif
            end
         end
`ifdef RX_PARITY_EN
         S_PARITY: begin
            if (at_end) state_d = S_STOP;
         end
`endif
         S_STOP: begin
            if (at_end) state_d = rxs_q ? S_IDLE : S_WAIT;
         end
         S_WAIT: begin
            if (rxs_q) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // FSM outputs: busy flag and per-state sampling strobes
   always_comb begin
      busy       = 1'b1;
      clr_idx    = 1'b0;
      sample_bit = 1'b0;
      stop_good  = 1'b0;
      stop_bad   = 1'b0;
`ifdef RX_PARITY_EN
      sample_par = 1'b0;
`endif
      case (state_q)
         S_IDLE:   busy = 1'b0;
         S_START:  clr_idx = at_half && !rxs_q;
         S_DATA:   sample_bit = at_end;
`ifdef RX_PARITY_EN
         S_PARITY: sample_par = at_end;
`endif
         S_STOP: begin
            stop_good = at_end && rxs_q;
            stop_bad  = at_end && !rxs_q;
         end
         default: ;
      endcase
   end

   // datapath next-state: bit counter, shift register, output byte and pulses
   always_comb begin
      // counter restarts on every state change so each state measures from its own entry
      if (state_d != state_q) cnt_d = '0;
      else if (at_end)        cnt_d = '0;
      else                    cnt_d = cnt_q + 1'b1;

      bit_idx_d = bit_idx_q;
      if (clr_idx)         bit_idx_d = '0;
      else if (sample_bit) bit_idx_d = bit_idx_q + 1'b1;

      shift_d = shift_q;
      if (sample_bit) shift_d[bit_idx_q] = rxs_q;

      data_d = stop_good ? shift_q : data_q;
      dv_d   = stop_good;
      fe_d   = stop_bad;

      settle_d = settled ? 2'd2 : settle_q + 2'd1;
      armed_d  = armed_q || (settled && rxs_q);
   end

   // datapath registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q     <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
         data_q    <= '0;
         dv_q      <= 1'b0;
         fe_q      <= 1'b0;
         settle_q  <= 2'd0;
         armed_q   <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         data_q    <= data_d;
         dv_q      <= dv_d;
         fe_q      <= fe_d;
         settle_q  <= settle_d;
         armed_q   <= armed_d;
      end
   end

`ifdef RX_PARITY_EN
   // parity verdict is held until the stop bit resolves so the error lines up with data_valid/frame_err
   always_comb begin
      par_bad_d = sample_par ? ((^shift_q) ^ rxs_q) : par_bad_q;
      pe_d      = (stop_good || stop_bad) && par_bad_q;
   end

   // parity registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         par_bad_q <= 1'b0;
         pe_q      <= 1'b0;
      end else begin
         par_bad_q <= par_bad_d;
         pe_q      <= pe_d;
      end
   end

   assign parity_err = pe_q;
`else
   assign parity_err = 1'b0;
`endif

   assign data_out   = data_q;
   assign data_valid = dv_q;
   assign frame_err  = fe_q;

endmodule

// File: tb/tb_rs232_rx_sipo.sv
// tb_rs232_rx_sipo: randomized and directed frames against a frame-level expectation queue.
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_rs232_rx_sipo;

   localparam int N = 8;
`ifdef RX_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       rxd = 1'b1;
   logic [7:0] data_out;
   logic       data_valid;
   logic       frame_err;
   logic       parity_err;
   logic       busy;

   rs232_rx_sipo #(.CLKS_PER_BIT(N), .DATA_BITS(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .rxd        (rxd),
      .data_out   (data_out),
      .data_valid (data_valid),
      .frame_err  (frame_err),
      .parity_err (parity_err),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // observed events, sampled on the falling edge
   logic [7:0]  obs_dat[$];
   logic        obs_pe[$];
   int unsigned obs_cyc[$];
   int          fe_cnt    = 0;
   int          pe_alone  = 0;
   int          both_cnt  = 0;

   always @(negedge clk) begin
      if (data_valid) begin
         obs_dat.push_back(data_out);
         obs_pe.push_back(parity_err);
         obs_cyc.push_back(cyc);
      end
      if (frame_err) fe_cnt++;
      if (parity_err && !data_valid) pe_alone++;
      if (data_valid && frame_err) both_cnt++;
   end

   // frame-level reference: every frame with a high stop bit yields its byte,
   // a low stop bit yields one framing error and nothing else
   logic [7:0] exp_dat[$];
   logic       exp_pe[$];
   int         exp_fe = 0;

   task automatic drive_bit(input logic v);
      rxd = v;
      repeat (N) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_v, input logic par_flip);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(b[i]);
      if (PAR_EN) drive_bit((^b) ^ par_flip);
      drive_bit(stop_v);
      if (stop_v) begin
         exp_dat.push_back(b);
         exp_pe.push_back(PAR_EN && par_flip);
      end else begin
         exp_fe++;
      end
   endtask

   task automatic scoreboard(input string tag);
      logic [7:0] d, e;
      logic       p, q;
      repeat (2 * N) @(negedge clk);
      chk({tag, "_count"}, obs_dat.size(), exp_dat.size());
      while (obs_dat.size() > 0 && exp_dat.size() > 0) begin
         d = obs_dat.pop_front();
         e = exp_dat.pop_front();
         p = obs_pe.pop_front();
         q = exp_pe.pop_front();
         chk({tag, "_data"}, d, e);
         chk({tag, "_parity_err"}, p, q);
      end
      obs_dat.delete();
      obs_pe.delete();
      obs_cyc.delete();
      exp_dat.delete();
      exp_pe.delete();
      chk({tag, "_frame_err"}, fe_cnt, exp_fe);
      chk({tag, "_dv_fe_overlap"}, both_cnt, 0);
      chk({tag, "_pe_alone"}, pe_alone, 0);
   endtask

   initial begin
      int unsigned t0;
      int unsigned lat;
      logic [7:0]  b;

      // reset state
      rxd = 1'b1;
      rst = 1'b0;
      repeat (4) @(negedge clk);
      chk("rst_data_out", data_out, 8'h00);
      chk("rst_data_valid", data_valid, 1'b0);
      chk("rst_frame_err", frame_err, 1'b0);
      chk("rst_parity_err", parity_err, 1'b0);
      chk("rst_busy", busy, 1'b0);
      rst = 1'b1;
      repeat (4) @(negedge clk);

      // single byte with latency
      t0 = cyc;
      send_frame(8'hA5, 1'b1, 1'b0);
      lat = (obs_cyc.size() > 0) ? obs_cyc[0] - t0 : 0;
      chk("latency_in_window", (lat >= 78 && lat <= 80), 1'b1);
      scoreboard("single");
      chk("single_hold", data_out, 8'hA5);

      // back-to-back, no idle gap
      send_frame(8'h00, 1'b1, 1'b0);
      send_frame(8'hFF, 1'b1, 1'b0);
      send_frame(8'h3C, 1'b1, 1'b0);
      scoreboard("b2b");

      // glitch shorter than half a bit
      rxd = 1'b0;
      repeat (2) @(negedge clk);
      rxd = 1'b1;
      repeat (2) @(negedge clk);
      chk("glitch_busy_hi", busy, 1'b1);
      repeat (N) @(negedge clk);
      chk("glitch_busy_lo", busy, 1'b0);
      scoreboard("glitch");

      // framing error followed by a long break
      send_frame(8'h5A, 1'b0, 1'b0);
      rxd = 1'b0;
      repeat (30 * N) @(negedge clk);
      chk("break_busy", busy, 1'b1);
      chk("break_data_held", data_out, 8'h3C);
      chk("break_frame_err_once", fe_cnt, 1);
      chk("break_no_valid", obs_dat.size(), 0);
      rxd = 1'b1;
      repeat (N) @(negedge clk);
      send_frame(8'h81, 1'b1, 1'b0);
      scoreboard("ferr");
      chk("ferr_after", data_out, 8'h81);

      // randomized traffic with random gaps and parity corruption
      for (int k = 0; k < 24; k++) begin
         b = 8'($urandom_range(0, 255));
         send_frame(b, 1'b1, 1'($urandom_range(0, 1)));
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      scoreboard("random");

      // reset during data bit 4
      drive_bit(1'b0);
      b = 8'hC3;
      for (int i = 0; i < 4; i++) drive_bit(b[i]);
      rxd = b[4];
      repeat (N / 2) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("midrst_data_out", data_out, 8'h00);
      chk("midrst_busy", busy, 1'b0);
      chk("midrst_valid", data_valid, 1'b0);
      rxd = 1'b1;
      repeat (N) @(negedge clk);
      rst = 1'b1;
      repeat (2 * N) @(negedge clk);
      send_frame(8'h81, 1'b1, 1'b0);
      scoreboard("midrst");
      chk("midrst_after", data_out, 8'h81);

      // line held low through reset release must not start a frame
      rxd = 1'b0;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (20 * N) @(negedge clk);
      chk("lowrst_busy", busy, 1'b1);
      chk("lowrst_data_out", data_out, 8'h00);
      scoreboard("lowrst");
      rxd = 1'b1;
      repeat (N) @(negedge clk);
      send_frame(8'h55, 1'b1, 1'b0);
      scoreboard("lowrst_frame");

      // wrong parity bit on 0x07 (parity_err expected only with parity enabled)
      send_frame(8'h07, 1'b1, 1'b1);
      scoreboard("parity");
      chk("parity_data_out", data_out, 8'h07);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rs232_rx_sipo.md
Name: rs232_rx_sipo

Overview:
- Serial-in/parallel-out RS232 receive stage, 8N1 framing, LSB first.
- Sits directly downstream of the transmit-side PISO on the serial line; converts the serial bit stream back into bytes.
- Detects the start bit and samples each bit at mid-bit using an internal bit-period counter.
- Presents each received byte with a one-cycle valid strobe and reports framing errors.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per serial bit (50 MHz / 115200). Legal range is >= 4.
- DATA_BITS, 8, data bits per frame. Fixed at 8; the parameter exists only for documentation and width expressions.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- rxd  input  1  serial line; idles high; asynchronous to clk.
- data_out  output  8  last good received byte; held until the next good frame.
- data_valid  output  1  one-cycle pulse; data_out is new and valid in that cycle.
- frame_err  output  1  one-cycle pulse; stop bit was sampled low.
- parity_err  output  1  one-cycle pulse on parity mismatch; constant 0 without RX_PARITY_EN.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (rst low, async): state=IDLE, data_out=8'h00, data_valid=0, frame_err=0, parity_err=0, busy=0, counters=0, both synchronizer flops=1 (line idle).
- Synchronizer:
  - rxd passes through a 2-flop synchronizer; all decisions use the synchronized value rxs.
  - Two cycles of input latency.
- Bit counter:
  - Width $clog2(CLKS_PER_BIT).
  - Counts 0..CLKS_PER_BIT-1, then wraps to 0.
  - Cleared on every state change.
- IDLE:
  - rxs==0 -> START, counter cleared.
  - Otherwise stay.
- START:
  - At count CLKS_PER_BIT/2-1 (integer floor), sample rxs.
  - rxs==0 -> DATA, with bit index=0.
  - rxs==1 -> IDLE as a glitch: no output pulse.
- DATA:
  - At count CLKS_PER_BIT-1, sample rxs into shift register position bit index. LSB first: the first data bit is data_out[0].
  - After bit index 7 -> STOP (or PARITY, see Optional Feature).
- STOP:
  - At count CLKS_PER_BIT-1, sample rxs.
  - Sample ==1:
    - Load data_out from the shift register.
    - Assert data_valid for exactly one cycle (the cycle after the sample edge).
    - Go to IDLE.
  - Sample ==0:
    - Assert frame_err for one cycle; data_out is unchanged.
    - Go to WAIT_IDLE.
- WAIT_IDLE:
  - Stay until rxs==1, then go to IDLE.
  - A break or stuck-low line generates no further frames or errors.
- Back-to-back frames:
  - A new start edge is accepted in the first IDLE cycle after STOP.
  - No minimum gap beyond the stop bit.
- Error pulses:
  - data_valid and frame_err are never high in the same cycle.
  - parity_err may coincide with data_valid.
- busy:
  - busy=1 in START, DATA, PARITY, STOP and WAIT_IDLE.
  - busy=0 only in IDLE.
- Reset mid-frame:
  - Immediately abandons the frame and returns to reset values.
  - No pulse is emitted.
  - After release, a line held low does not start a frame until it has been seen high. Implement this by entering WAIT_IDLE after reset when rxs==0.
- Latency (reference points are the rxd falling edge and the data_valid rise):
  - 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles (±1 cycle synchronizer phase).
  - At CLKS_PER_BIT=8 this is 79 cycles.

Optional Feature:
- Macro: RX_PARITY_EN.
- Defined:
  - The frame is 8E1. A PARITY state is inserted between DATA and STOP and samples one bit at count CLKS_PER_BIT-1.
  - Even parity: if XOR of the 8 data bits and the parity bit is 1, parity_err pulses for one cycle at the same time the stop bit is resolved.
  - The byte is still delivered if the stop bit is good.
- Undefined:
  - No PARITY state; frames are 8N1.
  - parity_err is tied to 0.

Test Plan:
- Reset: hold rst low with rxd=1 -> data_out=8'h00, data_valid=0, frame_err=0, parity_err=0, busy=0.
- Single byte, CLKS_PER_BIT=8: send 0xA5 8N1 -> exactly one data_valid pulse, data_out=8'hA5, frame_err=0. The pulse occurs within 79±1 cycles of the start edge.
- Back-to-back: send 0x00, 0xFF, 0x3C with no idle gap -> three data_valid pulses in order with data_out 8'h00, 8'hFF, 8'h3C.
- Glitch: drive rxd low for 2 cycles, then high -> no pulses; busy returns to 0 by mid-start-bit time.
- Framing error: send 0x5A with the stop bit low, then hold rxd low for 30 bit times, then send 0x81 -> one frame_err pulse, data_out stays at its previous value, no activity while low. Then one data_valid with data_out=8'h81.
- Mid-frame reset and parity:
  - Assert rst during data bit 4 -> outputs return to reset values, no pulse.
  - Then send 0x81 -> data_valid with data_out=8'h81.
  - With RX_PARITY_EN, sending 0x07 with parity bit 0 -> data_valid plus a parity_err pulse.
